// File: rtl/tblink_rpc_invoke_framer_if.sv
// Request, frame-word and completion signals shared by the BFM, the invoke framer
// and the TBLink endpoint. master = BFM/endpoint side, slave = framer side.
interface tblink_rpc_invoke_framer_if #(
    parameter int DATA_W     = 32,
    parameter int METHOD_W   = 16,
    parameter int MAX_PARAMS = 8,
    parameter int ID_W       = 4
);
    logic                         req_valid;
    logic                         req_ready;
    logic [METHOD_W-1:0]          req_method_id;
    logic                         req_blocking;
    logic [7:0]                   req_nparams;
    logic [MAX_PARAMS*DATA_W-1:0] req_params;
    logic [ID_W-1:0]              req_id;

    logic                         msg_valid;
    logic                         msg_ready;
    logic [DATA_W-1:0]            msg_data;
    logic                         msg_last;

    logic                         rsp_valid;
    logic [ID_W-1:0]              rsp_id;
    logic [DATA_W-1:0]            rsp_data;

    logic                         done_valid;
    logic [ID_W-1:0]              done_id;
    logic [DATA_W-1:0]            done_data;

    modport master (
        output req_valid, req_method_id, req_blocking, req_nparams, req_params,
        output msg_ready, rsp_valid, rsp_id, rsp_data,
        input  req_ready, req_id, msg_valid, msg_data, msg_last,
        input  done_valid, done_id, done_data
    );

    modport slave (
        input  req_valid, req_method_id, req_blocking, req_nparams, req_params,
        input  msg_ready, rsp_valid, rsp_id, rsp_data,
        output req_ready, req_id, msg_valid, msg_data, msg_last,
        output done_valid, done_id, done_data
    );
endinterface

// File: rtl/tblink_rpc_invoke_framer.sv
// Serializes BFM method invocations into header+parameter frames for the TBLink
// endpoint, allocating call IDs for blocking calls and matching their completions.
//
// state   | meaning
// S_IDLE  | no frame in flight; accepts a request when an ID slot is free
// S_HDR   | header word on msg_*, waiting for the endpoint handshake
// S_PARAM | parameter word r_idx on msg_*, waiting for the endpoint handshake
module tblink_rpc_invoke_framer #(
    parameter int DATA_W     = 32,
    parameter int METHOD_W   = 16,
    parameter int MAX_PARAMS = 8,
    parameter int ID_W       = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    tblink_rpc_invoke_framer_if.slave bus,
    output logic [ID_W:0]             outstanding,
    output logic                      err_unexpected,
    output logic                      err_nparams
);
    localparam int         NIDS   = 1 << ID_W;
    localparam int         IDX_W  = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
    localparam logic [7:0] MAX_NP = 8'(MAX_PARAMS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_PARAM = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;

    logic [METHOD_W-1:0]   r_method;
    logic                  r_blocking;
    logic [7:0]            r_nparams;
    logic [DATA_W-1:0]     r_params [MAX_PARAMS];
    logic [ID_W-1:0]       r_id;
    logic [NIDS-1:0]       r_bitmap;
    logic [ID_W:0]         r_outstanding;
    logic                  r_done_valid;
    logic [ID_W-1:0]       r_done_id;
    logic [DATA_W-1:0]     r_done_data;
    logic                  r_err_unexp;
    logic                  r_err_np;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_alloc;
    logic                  w_np_over;
    logic [7:0]            w_np_clamped;
    logic [ID_W-1:0]       w_free_id;
    logic                  w_rsp_hit;
    logic [NIDS-1:0]       w_alloc_mask;
    logic [NIDS-1:0]       w_rel_mask;
    logic                  w_last_param;
    logic [DATA_W-1:0]     w_hdr;
    logic                  w_msg_valid;
    logic                  w_msg_last;
    logic [DATA_W-1:0]     w_msg_data;

    // Lowest-numbered free ID from the bitmap as it stood before this cycle's release.
    always_comb begin
        w_free_id = '0;
        for (int i = NIDS - 1; i >= 0; i--) begin
            if (!r_bitmap[i]) begin
                w_free_id = ID_W'(i);
            end
        end
    end

    assign w_req_ready  = reset_n && (r_state == S_IDLE) &&
                          (r_outstanding < (ID_W + 1)'(NIDS));
    assign w_accept     = bus.req_valid && w_req_ready;
    assign w_alloc      = w_accept && bus.req_blocking;
    assign w_np_over    = bus.req_nparams > MAX_NP;
    assign w_np_clamped = w_np_over ? MAX_NP : bus.req_nparams;
    assign w_rsp_hit    = bus.rsp_valid && r_bitmap[bus.rsp_id];
    assign w_last_param = (8'(r_idx) == (r_nparams - 8'd1));

    always_comb begin
        w_alloc_mask = '0;
        w_rel_mask   = '0;
        if (w_alloc) begin
            w_alloc_mask[w_free_id] = 1'b1;
        end
        if (w_rsp_hit) begin
            w_rel_mask[bus.rsp_id] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (bus.msg_ready) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = (r_nparams == 8'd0) ? S_IDLE : S_PARAM;
                end
            end
            S_PARAM: begin
                if (bus.msg_ready) begin
                    if (w_last_param) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame words come straight from latched request state, so they hold under backpressure.
    always_comb begin
        w_hdr                           = '0;
        w_hdr[METHOD_W-1:0]             = r_method;
        w_hdr[METHOD_W +: 8]            = r_nparams;
        w_hdr[METHOD_W + 8 +: ID_W]     = r_id;
        w_hdr[DATA_W-1]                 = r_blocking;
        w_msg_valid                     = 1'b0;
        w_msg_last                      = 1'b0;
        w_msg_data                      = '0;
        case (r_state)
            S_HDR: begin
                w_msg_valid = 1'b1;
                w_msg_last  = (r_nparams == 8'd0);
                w_msg_data  = w_hdr;
            end
            S_PARAM: begin
                w_msg_valid = 1'b1;
                w_msg_last  = w_last_param;
                w_msg_data  = r_params[r_idx];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_method      <= '0;
            r_blocking    <= 1'b0;
            r_nparams     <= '0;
            r_id          <= '0;
            r_bitmap      <= '0;
            r_outstanding <= '0;
            r_done_valid  <= 1'b0;
            r_done_id     <= '0;
            r_done_data   <= '0;
            r_err_unexp   <= 1'b0;
            r_err_np      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_method   <= bus.req_method_id;
                r_blocking <= bus.req_blocking;
                r_nparams  <= w_np_clamped;
                r_id       <= bus.req_blocking ? w_free_id : '0;
                if (w_np_over) begin
                    r_err_np <= 1'b1;
                end
            end
            // An ID allocated here is free in the old bitmap, so it never collides with a release.
            r_bitmap      <= (r_bitmap | w_alloc_mask) & ~w_rel_mask;
            r_outstanding <= r_outstanding + (ID_W + 1)'(w_alloc) - (ID_W + 1)'(w_rsp_hit);
            r_done_valid  <= w_rsp_hit;
            if (w_rsp_hit) begin
                r_done_id   <= bus.rsp_id;
                r_done_data <= bus.rsp_data;
            end
            if (bus.rsp_valid && !w_rsp_hit) begin
                r_err_unexp <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int i = 0; i < MAX_PARAMS; i++) begin
                r_params[i] <= bus.req_params[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.req_id      = r_id;
    assign bus.msg_valid   = w_msg_valid;
    assign bus.msg_data    = w_msg_data;
    assign bus.msg_last    = w_msg_last;
    assign bus.done_valid  = r_done_valid;
    assign bus.done_id     = r_done_id;
    assign bus.done_data   = r_done_data;
    assign outstanding     = r_outstanding;
    assign err_unexpected  = r_err_unexp;
    assign err_nparams     = r_err_np;
endmodule

// File: doc/tblink_rpc_invoke_framer.md
# tblink_rpc_invoke_framer

Synthesizable HDL-side stage that sits directly upstream of the TBLink SV endpoint dispatcher. It accepts method-invocation requests from a BFM, assigns call IDs to blocking calls, and serializes each request into a framed word stream (header plus parameters) for the endpoint. It then matches blocking-call completions returned by the endpoint against outstanding IDs.

## Interface
Parameters:
- DATA_W, 32, message word width; must satisfy METHOD_W+8+ID_W < DATA_W
- METHOD_W, 16, method-ID width
- MAX_PARAMS, 8, maximum parameter words per call
- ID_W, 4, call-ID width; 2**ID_W outstanding blocking calls

Ports:
- clock  in  1  single clock; all logic is rising-edge
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when valid&&ready
- req_method_id  in  METHOD_W  method ID
- req_blocking  in  1  1 = blocking call; allocates an ID
- req_nparams  in  8  number of parameter words
- req_params  in  MAX_PARAMS*DATA_W  parameter words; word i is at [i*DATA_W +: DATA_W]
- req_id  out  ID_W  ID assigned at the last accept; 0 for non-blocking calls
- msg_valid  out  1  frame word valid
- msg_ready  in  1  endpoint accepts word
- msg_data  out  DATA_W  frame word
- msg_last  out  1  final word of frame
- rsp_valid  in  1  blocking-call completion
- rsp_id  in  ID_W  completed call ID
- rsp_data  in  DATA_W  return value
- done_valid  out  1  completion pulse (one cycle, no backpressure)
- done_id  out  ID_W  completed ID
- done_data  out  DATA_W  return value
- outstanding  out  ID_W+1  count of IDs in use
- err_unexpected  out  1  sticky: rsp_id was not in use
- err_nparams  out  1  sticky: req_nparams > MAX_PARAMS

## Operation
- FSM states: IDLE, HDR, PARAM.
- IDLE: req_ready = (outstanding < 2**ID_W). A blocking or non-blocking request can stall only when the table is full. On accept:
  - latch method, blocking flag, nparams and params;
  - a blocking call allocates the lowest-numbered free ID and sets its in-use bit;
  - go to HDR.
- Header word:
  - [METHOD_W-1:0] = method ID;
  - [METHOD_W+7:METHOD_W] = nparams;
  - [METHOD_W+8+ID_W-1:METHOD_W+8] = ID;
  - [DATA_W-1] = blocking;
  - all other bits 0.
- HDR: msg_valid=1.
  - msg_last = (nparams==0).
  - On handshake, go to PARAM with index 0, or to IDLE if nparams==0.
- PARAM: msg_data = param[index], msg_valid=1, msg_last = (index==nparams-1).
  - On handshake, index++.
  - After the last word, go to IDLE.
- msg_data, msg_valid and msg_last hold stable while msg_ready=0.
- nparams > MAX_PARAMS: the value is clamped to MAX_PARAMS in the latch and in the header, and err_nparams is set.
- Completion: rsp_valid with rsp_id in use clears the bit. The next cycle asserts done_valid for one cycle with done_id and done_data. If rsp_id is not in use, the response is dropped and err_unexpected is set.
- rsp_valid is accepted in any FSM state.
- Accept and release in the same cycle:
  - allocation uses the pre-release bitmap;
  - outstanding is unchanged (+1 and −1);
  - a released ID becomes allocatable the following cycle.
- Error flags clear only on reset.

## Timing
- Reset (reset_n=0 at a rising edge) sets:
  - FSM to IDLE; bitmap, outstanding, req_id, done_* and err_* to 0;
  - msg_valid=0, msg_last=0, msg_data=0.
- req_ready is forced to 0 while reset_n=0.
- Reset mid-frame aborts the frame: msg_valid is 0 after that edge, and no partial frame resumes.
- Accept at edge N: header is on msg_* from N (registered) until its handshake; req_id is valid from N.
- Throughput: one frame word per cycle with msg_ready held high. A frame with p params occupies p+1 cycles. req_ready returns in the cycle after the last-word handshake, so there is one idle cycle between frames.
- done_valid latency: one cycle after the rsp_valid edge.

## Test plan
- Non-blocking call, method 0x0012, nparams=2, params 0xA, 0xB, msg_ready=1:
  - words 0x0002_0012, 0xA, 0xB;
  - msg_last on 0xB only;
  - req_id=0; outstanding stays 0.
- Blocking call, nparams=0:
  - header 0x8000_0007 for method 7, ID 0, with msg_last=1;
  - outstanding=1;
  - then rsp_id=0, rsp_data=0x55 gives done_valid one cycle later with done_id=0, done_data=0x55; outstanding=0.
- 16 back-to-back blocking calls:
  - IDs 0..15 assigned in order;
  - req_ready=0 on the 17th;
  - rsp_id=5 releases ID 5, and the 17th call is accepted with ID 5.
- msg_ready toggling 1/0 every cycle during a 3-param frame:
  - words are delivered in order and unchanged while stalled;
  - the frame takes 8 cycles.
- rsp_id=3 when not in use: no done_valid, err_unexpected=1.
- req_nparams=12: err_nparams=1 and the header nparams field is 8. Separately, reset asserted during param 1 of a frame: msg_valid=0 next cycle and outstanding=0.
